// File: rtl/mux_arbiter.sv
// mux_arbiter: two-channel valid/ready arbiter feeding a 2:1 mux.
// Each input channel has a one-entry holding buffer. A round-robin FSM picks
// which full buffer drives the mux, and the muxed byte is captured in a
// registered output stage with its own valid/ready handshake.
// Optional grant counters are enabled by defining MUX_ARB_CNT_EN; without it
// gnt_cnt_a and gnt_cnt_b are tied to zero and no counter flops exist.
module mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [7:0]       gnt_cnt_a,
  output logic [7:0]       gnt_cnt_b
);

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} arb_state_t;

  arb_state_t       state_q, state_d;
  logic             a_full_q, a_full_d;
  logic             b_full_q, b_full_d;
  logic [WIDTH-1:0] a_buf_q, a_buf_d;
  logic [WIDTH-1:0] b_buf_q, b_buf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;

  logic             load;
  logic             grant_a;
  logic             grant_b;
  logic             sel;
  logic [WIDTH-1:0] mux_f;
  logic             a_accept;
  logic             b_accept;

  // Ready comes from the full flag only, so there is no path from valid or out_ready.
  assign a_ready   = !a_full_q;
  assign b_ready   = !b_full_q;
  assign a_accept  = a_valid && !a_full_q;
  assign b_accept  = b_valid && !b_full_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // Grant decision: a load needs a free (or draining) output slot and a full buffer;
  // when both buffers are full the FSM state breaks the tie.
  always_comb begin
    load    = (!out_valid_q || out_ready) && (a_full_q || b_full_q);
    grant_a = load && a_full_q && (!b_full_q || (state_q == PRI_A));
    grant_b = load && b_full_q && (!a_full_q || (state_q == PRI_B));
    sel     = grant_b;
    mux_f   = sel ? b_buf_q : a_buf_q;
  end

  // Next-state for buffers, arbiter state and the output register.
  always_comb begin
    state_d     = state_q;
    a_full_d    = a_full_q;
    b_full_d    = b_full_q;
    a_buf_d     = a_buf_q;
    b_buf_d     = b_buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    // Accept and grant on one channel are mutually exclusive (empty vs full).
    if (a_accept) begin
      a_buf_d  = a_data;
      a_full_d = 1'b1;
    end else if (grant_a) begin
      a_full_d = 1'b0;
    end

    if (b_accept) begin
      b_buf_d  = b_data;
      b_full_d = 1'b1;
    end else if (grant_b) begin
      b_full_d = 1'b0;
    end

    if (grant_a) begin
      state_d = PRI_B;
    end else if (grant_b) begin
      state_d = PRI_A;
    end

    // A load replaces a draining byte in the same edge, so there is no bubble.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_f;
      out_src_d   = sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Registers for the FSM, channel buffers and output stage; reset discards all data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PRI_A;
      a_full_q    <= 1'b0;
      b_full_q    <= 1'b0;
      a_buf_q     <= '0;
      b_buf_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_full_q    <= a_full_d;
      b_full_q    <= b_full_d;
      a_buf_q     <= a_buf_d;
      b_buf_q     <= b_buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

`ifdef MUX_ARB_CNT_EN
  logic [7:0] cnt_a_q, cnt_a_d;
  logic [7:0] cnt_b_q, cnt_b_d;

  // Saturating grant counters; they never wrap and clear only on reset.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (grant_a && (cnt_a_q != 8'hFF)) begin
      cnt_a_d = cnt_a_q + 8'd1;
    end
    if (grant_b && (cnt_b_q != 8'hFF)) begin
      cnt_b_d = cnt_b_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= 8'd0;
      cnt_b_q <= 8'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign gnt_cnt_a = cnt_a_q;
  assign gnt_cnt_b = cnt_b_q;
`else
  assign gnt_cnt_a = 8'd0;
  assign gnt_cnt_b = 8'd0;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Testbench for mux_arbiter: directed vectors, with a scoreboard monitor that
// checks every byte leaving the output handshake against per-channel queues.
module tb_mux_arbiter;

   logic       clk;
   logic       rst_n;
   logic       aValid, aReady;
   logic [7:0] aData;
   logic       bValid, bReady;
   logic [7:0] bData;
   logic       outValid, outReady;
   logic [7:0] outData;
   logic       outSrc;
   logic [7:0] gntCntA, gntCntB;

   int checkCount = 0;
   int errorCount = 0;

   logic [7:0] expA[$];
   logic [7:0] expB[$];
   logic [8:0] outLog[$];
   logic       sweepDone;

   mux_arbiter #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (aValid),
      .a_ready   (aReady),
      .a_data    (aData),
      .b_valid   (bValid),
      .b_ready   (bReady),
      .b_data    (bData),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .out_src   (outSrc),
      .gnt_cnt_a (gntCntA),
      .gnt_cnt_b (gntCntB)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and report a failure line if it differs.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Offer one byte on channel ch (0 = A, 1 = B); returns just after the accepting edge.
   task automatic applyStimulus(input bit ch, input logic [7:0] d);
      bit accepted;
      accepted = 1'b0;
      if (ch) begin bValid = 1'b1; bData = d; end
      else    begin aValid = 1'b1; aData = d; end
      for (int i = 0; i < 2000 && !accepted; i++) begin
         @(negedge clk);
         if ((ch ? bReady : aReady) && rst_n) begin
            accepted = 1'b1;
            if (ch) expB.push_back(d);
            else    expA.push_back(d);
         end
      end
      if (!accepted) begin
         errorCount++;
         $display("[TB] FAIL handshake_timeout: channel %0d byte 0x%0h not accepted", ch, d);
      end
      @(posedge clk);
      #1;
      if (ch) bValid = 1'b0;
      else    aValid = 1'b0;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      expA.delete();
      expB.delete();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for both scoreboard queues to drain and the output to go idle.
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((expA.size() != 0 || expB.size() != 0 || outValid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({name, "_drained"}, {30'd0, (expA.size() == 0), (expB.size() == 0)}, 32'd3);
   endtask

   // Scoreboard monitor: a byte moves at the next edge when valid and ready are both high.
   always @(negedge clk) begin
      if (rst_n && outValid && outReady) begin
         outLog.push_back({outSrc, outData});
         if (outSrc) begin
            if (expB.size() == 0) begin
               errorCount++;
               $display("[TB] FAIL sb_unexpected_b: got 0x%0h, expected nothing", outData);
            end else begin
               checkOutput("sb_data_b", {24'd0, outData}, {24'd0, expB.pop_front()});
            end
         end else begin
            if (expA.size() == 0) begin
               errorCount++;
               $display("[TB] FAIL sb_unexpected_a: got 0x%0h, expected nothing", outData);
            end else begin
               checkOutput("sb_data_a", {24'd0, outData}, {24'd0, expA.pop_front()});
            end
         end
`ifndef MUX_ARB_CNT_EN
         checkOutput("cnt_off_a", {24'd0, gntCntA}, 32'd0);
         checkOutput("cnt_off_b", {24'd0, gntCntB}, 32'd0);
`endif
      end
   end

   initial begin
      logic [8:0] rrExp[6];
      int n;
      rrExp[0] = 9'h001; rrExp[1] = 9'h181; rrExp[2] = 9'h002;
      rrExp[3] = 9'h182; rrExp[4] = 9'h003; rrExp[5] = 9'h183;

      rst_n = 1'b0; aValid = 1'b0; bValid = 1'b0;
      aData = 8'h00; bData = 8'h00; outReady = 1'b0; sweepDone = 1'b0;
      #1;
      applyReset();

      // Reset values
      checkOutput("rst_a_ready", {31'd0, aReady}, 32'd1);
      checkOutput("rst_b_ready", {31'd0, bReady}, 32'd1);
      checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("rst_out_data", {24'd0, outData}, 32'd0);
      checkOutput("rst_out_src", {31'd0, outSrc}, 32'd0);
      checkOutput("rst_cnt_a", {24'd0, gntCntA}, 32'd0);
      checkOutput("rst_cnt_b", {24'd0, gntCntB}, 32'd0);

      // Single channel: 0x3C through A with latency of one edge after the accept
      outReady = 1'b1;
      applyStimulus(1'b0, 8'h3C);
      checkOutput("single_valid_early", {31'd0, outValid}, 32'd0);
      checkOutput("single_a_ready_busy", {31'd0, aReady}, 32'd0);
      @(posedge clk); #1;
      checkOutput("single_valid", {31'd0, outValid}, 32'd1);
      checkOutput("single_data", {24'd0, outData}, 32'h3C);
      checkOutput("single_src", {31'd0, outSrc}, 32'd0);
      checkOutput("single_a_ready_back", {31'd0, aReady}, 32'd1);
      waitDrain("single");

      // Round-robin with both channels kept full from reset
      applyReset();
      outReady = 1'b1;
      outLog.delete();
      fork
         begin applyStimulus(1'b0, 8'h01); applyStimulus(1'b0, 8'h02); applyStimulus(1'b0, 8'h03); end
         begin applyStimulus(1'b1, 8'h81); applyStimulus(1'b1, 8'h82); applyStimulus(1'b1, 8'h83); end
      join
      waitDrain("rr");
      checkOutput("rr_count", outLog.size(), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < outLog.size()) checkOutput($sformatf("rr_order_%0d", i), {23'd0, outLog[i]}, {23'd0, rrExp[i]});
      end

      // Backpressure: 0xAA held on output, 0x55 waiting in B
      outReady = 1'b0;
      applyStimulus(1'b0, 8'hAA);
      applyStimulus(1'b1, 8'h55);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_data", {24'd0, outData}, 32'hAA);
         checkOutput("bp_valid", {31'd0, outValid}, 32'd1);
         checkOutput("bp_b_ready", {31'd0, bReady}, 32'd0);
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_next_data", {24'd0, outData}, 32'h55);
      checkOutput("bp_next_src", {31'd0, outSrc}, 32'd1);
      checkOutput("bp_next_valid", {31'd0, outValid}, 32'd1);
      waitDrain("bp");

      // Reset mid-stream with both buffers full and the output occupied
      outReady = 1'b0;
      applyStimulus(1'b0, 8'h11);
      applyStimulus(1'b0, 8'h22);
      applyStimulus(1'b1, 8'h33);
      checkOutput("pre_rst_valid", {31'd0, outValid}, 32'd1);
      checkOutput("pre_rst_full", {30'd0, aReady, bReady}, 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", {31'd0, outValid}, 32'd0);
      checkOutput("async_rst_ready", {30'd0, aReady, bReady}, 32'd3);
      checkOutput("async_rst_data", {24'd0, outData}, 32'd0);
      applyReset();
      outReady = 1'b1;
      outLog.delete();
      fork
         applyStimulus(1'b0, 8'h44);
         applyStimulus(1'b1, 8'h66);
      join
      waitDrain("post_rst");
      checkOutput("post_rst_count", outLog.size(), 32'd2);
      if (outLog.size() > 0) checkOutput("post_rst_first", {23'd0, outLog[0]}, 32'h044);

      // Counters: 300 A-only transfers from a fresh reset
      applyReset();
      outReady = 1'b1;
      for (int i = 0; i < 300; i++) applyStimulus(1'b0, i[7:0]);
      waitDrain("cnt");
`ifdef MUX_ARB_CNT_EN
      checkOutput("cnt_a_sat", {24'd0, gntCntA}, 32'd255);
`else
      checkOutput("cnt_a_off", {24'd0, gntCntA}, 32'd0);
`endif
      checkOutput("cnt_b_zero", {24'd0, gntCntB}, 32'd0);

      // Exhaustive data sweep on both channels under random out_ready
      fork
         begin
            fork
               for (int i = 0; i < 256; i++) applyStimulus(1'b0, i[7:0]);
               for (int j = 0; j < 256; j++) applyStimulus(1'b1, 8'hFF - j[7:0]);
            join
            sweepDone = 1'b1;
         end
         begin
            n = 0;
            while (!sweepDone && n < 20000) begin
               @(posedge clk); #1;
               outReady = $urandom_range(0, 1);
               n++;
            end
         end
      join
      outReady = 1'b1;
      waitDrain("sweep");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
